ec2_out_capture: RTL
====================

// Module: ec2_out_capture
// PURPOSE
//  Consumes the EC2 CPU's 16-bit Output bus and Halt flag, downstream of ec2top.
//  Every change of the CPU output value is queued in a small FIFO and offered on a valid/ready port for a host/logger.
//  On Halt: stops capturing, drains the queue, then raises Done.
// PARAMETERS
//  DATA_W   16  width of CPU output word
//  DEPTH    8   FIFO entries; power of two, >=2
//  CNT_W    4   $clog2(DEPTH)+1, occupancy counter width
// PORTS
//  Clock     in   1       single clock, all logic on posedge
//  Reset     in   1       synchronous, active-high; clears all state
//  CpuOut    in   DATA_W  ec2top Output bus
//  CpuHalt   in   1       ec2top Halt
//  OutData   out  DATA_W  head-of-queue word (show-ahead)
//  OutValid  out  1       queue non-empty
//  OutReady  in   1       consumer accepts; pop on OutValid&&OutReady at posedge
//  Count     out  CNT_W   current occupancy, 0..DEPTH
//  Overflow  out  1       sticky: a capture was dropped because queue full
//  Done      out  1       halt seen and queue fully drained
// BEHAVIOUR
//  Reset (sampled at posedge): state=RUN, prev_q=0, rd/wr ptr=0, Count=0, OutValid=0,
//   OutData=0 (mem not cleared; OutData gated to 0 when empty), Overflow=0, Done=0.
//  States: RUN -> DRAIN -> DONE; DONE holds until Reset. Encoding 2 bits.
//  RUN: each posedge, chg = (CpuOut != prev_q); prev_q <= CpuOut always.
//   chg && !full -> push CpuOut; OutValid high from the following cycle (1-cycle latency).
//   chg && full && !pop -> word dropped, Overflow <= 1 (sticky until Reset).
//   chg && full && pop -> push accepted, Count unchanged.
//   CpuHalt==1 -> next state DRAIN; capture in that same cycle still performed.
//  DRAIN: no captures (CpuOut ignored); pops continue; Count==0 -> DONE.
//   Count reaches 0 via pop at edge k -> state DONE at edge k+1, Done=1 after k+1.
//   Halt with empty queue: RUN->DRAIN->DONE, Done high 2 cycles after Halt sampled.
//  DONE: Done=1, OutValid=0, no push/pop.
//  Pop on empty ignored. Simultaneous push+pop on empty: push only (no bypass).
//  Pointers are log2(DEPTH) bits, wrap modulo DEPTH; full = Count==DEPTH.
//  Reset mid-operation (any state): all above reset values next cycle; queued data lost.
//  CpuHalt deasserting after DRAIN entered has no effect.
// STRUCTURE
//  ec2_pkg: state localparams (ST_RUN=0, ST_DRAIN=1, ST_DONE=2), EC2_DATA_W=16.
//  Sub-module ec2_sync_fifo (DATA_W, DEPTH): storage, ptrs, Count, full/empty,
//   push/pop with same-cycle rules above; top holds FSM, change detect, Overflow.
// TESTING
//  1 Reset held 2 cycles, CpuOut=31 -> OutValid=0, Count=0, Overflow=0, Done=0 throughout.
//  2 Release reset, CpuOut=31, OutReady=0 -> next cycle OutValid=1, OutData=31, Count=1; static input adds none.
//  3 OutReady=0, CpuOut steps 1..10 one per cycle -> Count=8, Overflow=1; then drain reads 1..8 in order.
//  4 Queue full, CpuOut changes to 0x00AA while OutReady=1 -> Count stays 8, 0x00AA last out, Overflow unchanged.
//  5 Three words queued, CpuHalt=1 pulse, then OutReady=1 -> 3 pops, Done=1 one cycle after Count=0; later CpuOut changes ignored.
//  6 Reset asserted in DRAIN with 4 entries -> next cycle Count=0, OutValid=0, Done=0, state RUN.

Source files
------------

// File: rtl/ec2_pkg.sv
// Shared constants for the EC2 output-capture block: FSM state codes and
// the default CPU output-bus width.
package ec2_pkg;

  // Default width of the ec2top Output bus
  localparam int EC2_DATA_W = 16;

  // Capture FSM state codes (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : ec2_pkg

// File: rtl/ec2_sync_fifo.sv
// Small synchronous show-ahead FIFO. A pop is ignored while empty, and a push
// is accepted while full only if a pop frees a slot on the same edge.
// There is no empty-queue bypass: a word pushed into an empty queue is visible
// on o_data from the next cycle. o_data reads as zero while the queue is empty.
module ec2_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_full    = (r_count == FULL_CNT);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_count   = r_count;
  assign o_data    = o_empty ? {DATA_W{1'b0}} : r_mem[r_rd_ptr];

  // Storage write; contents are deliberately not cleared by reset
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : ec2_sync_fifo

// File: rtl/ec2_out_capture.sv
// Captures every change of the EC2 CPU Output bus into a FIFO and offers it
// on a valid/ready port. On Halt, capture stops, the queue drains, and Done
// rises once the queue is empty. Done holds until Reset.
module ec2_out_capture
  import ec2_pkg::*;
#(
  parameter int DATA_W = EC2_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] CpuOut,
  input  logic              CpuHalt,
  output logic [DATA_W-1:0] OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CNT_W-1:0]  Count,
  output logic              Overflow,
  output logic              Done
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_prev_q;
  logic              r_overflow;
  logic              w_chg;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head;

  // A change is only a capture candidate while running
  assign w_chg = (r_state == ST_RUN) && (CpuOut != r_prev_q);
  // In DONE the queue is already empty, but the pop is blocked explicitly anyway
  assign w_pop = OutReady && (r_state != ST_DONE);

  ec2_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_chg),
    .i_data  (CpuOut),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state logic: RUN -> DRAIN on Halt, DRAIN -> DONE once empty
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (CpuHalt) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // State register and previous-output register used for change detection
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_RUN;
      r_prev_q <= {DATA_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_prev_q <= CpuOut;
    end
  end

  // Sticky overflow: a change arrived while full and no pop freed a slot
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_overflow <= 1'b0;
    end else if (w_chg && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign OutData  = w_head;
  assign OutValid = !w_empty && (r_state != ST_DONE);
  assign Count    = w_count;
  assign Overflow = r_overflow;
  assign Done     = (r_state == ST_DONE);

endmodule : ec2_out_capture
